// File: rtl/uart_rx_framed.sv
// UART receiver: oversampled start/data/stop framing, valid/ready holding
// register with overrun pulse and line-idle detection.
// Optional parity stage compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_framed #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 idle
);

    localparam int unsigned Div    = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int unsigned DivW   = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned OsW    = $clog2(OVERSAMPLE);
    localparam int unsigned BitW   = $clog2(DATA_BITS + 1);
    localparam int unsigned GapMax = 2 * OVERSAMPLE;
    localparam int unsigned GapW   = $clog2(GapMax + 1);

    localparam logic [DivW-1:0] DivLast  = DivW'(Div - 1);
    localparam logic [OsW-1:0]  OsHalf   = OsW'(OVERSAMPLE / 2 - 1);
    localparam logic [OsW-1:0]  OsLast   = OsW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0] BitLast  = BitW'(DATA_BITS - 1);
    localparam logic [GapW-1:0] GapFull  = GapW'(GapMax);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBreak
    } state_e;

    state_e                 state_q, state_d;
    logic [DivW-1:0]        div_cnt_q, div_cnt_d;
    logic [1:0]             sync_q, sync_d;
    logic [OsW-1:0]         os_cnt_q, os_cnt_d;
    logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [GapW-1:0]        gap_q, gap_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_q, overrun_d;
    logic                   perr_q, perr_d;

    logic tick, rxs, done, ferr, load, drop;

    assign tick = (div_cnt_q == DivLast);
    assign rxs  = sync_q[1];

`ifndef UART_RX_PARITY_EN
    // PARITY_ODD has no effect without the parity stage.
    logic unused_parity_odd;
    assign unused_parity_odd = ^(1'(PARITY_ODD));
`endif

    // Free-running tick divider and two-flop input synchroniser.
    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + DivW'(1);
        sync_d    = {sync_q[0], rxd};
    end

    // Frame state machine: mid-bit sampling, shift register and parity.
    always_comb begin
        state_d   = state_q;
        os_cnt_d  = tick ? os_cnt_q + OsW'(1) : os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        done      = 1'b0;
        ferr      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tick && !rxs) begin
                    os_cnt_d = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (tick && os_cnt_q == OsHalf) begin
                    if (rxs) begin
                        state_d = StIdle;
                    end else begin
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                        state_d   = StData;
                    end
                end
            end
            StData: begin
                if (tick && os_cnt_q == OsLast) begin
                    shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                    if (bit_cnt_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (tick && os_cnt_q == OsLast) begin
                    perr_d  = ^shift_q ^ rxs ^ 1'(PARITY_ODD);
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (tick && os_cnt_q == OsLast) begin
                    done    = 1'b1;
                    ferr    = ~rxs;
                    state_d = rxs ? StIdle : StBreak;
                end
            end
            StBreak: begin
                // A held-low line yields one word; wait for it to go high.
                if (tick && rxs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Holding register with valid/ready handshake; new word wins over accept.
    always_comb begin
        load         = done && (!rx_valid_q || rx_ready);
        drop         = done && rx_valid_q && !rx_ready;
        rx_data_d    = rx_data_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        rx_valid_d   = rx_valid_q;
        overrun_d    = drop;
        if (load) begin
            rx_data_d    = shift_q;
            frame_err_d  = ferr;
`ifdef UART_RX_PARITY_EN
            parity_err_d = perr_q;
`else
            parity_err_d = 1'b0;
`endif
            rx_valid_d   = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // Line-idle gap counter, saturating at two bit times.
    always_comb begin
        gap_d = '0;
        if (state_q == StIdle && rxs) begin
            gap_d = (tick && gap_q != GapFull) ? gap_q + GapW'(1) : gap_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            div_cnt_q    <= '0;
            sync_q       <= 2'b11;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            gap_q        <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            sync_q       <= sync_d;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            gap_q        <= gap_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign idle       = (gap_q == GapFull);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed at DIV=4, 64 clk per bit.
module tb_uart_rx_framed;

    localparam int unsigned BitClk = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun, idle;

    int n_pass = 0;
    int n_checks = 0;
    int word_cnt = 0;
    int ovr_cnt = 0;
    int vld_cycles = 0;
    int w0, v0;
    logic [7:0] last_data = 8'h00;
    logic       last_ferr = 1'b0;
    logic       last_perr = 1'b0;

    uart_rx_framed #(
        .CLK_FREQ  (6400000),
        .BAUD      (100000),
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .PARITY_ODD(0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    // Record accepted words and pulse counts away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) vld_cycles <= vld_cycles + 1;
        if (overrun) ovr_cnt <= ovr_cnt + 1;
        if (rx_valid && rx_ready) begin
            word_cnt  <= word_cnt + 1;
            last_data <= rx_data;
            last_ferr <= frame_err;
            last_perr <= parity_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        clks(BitClk);
    endtask

    // Start, 8 data bits LSB first, optional even parity (optionally corrupted), stop.
    task automatic send_frame(input logic [7:0] d, input logic par_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ ~par_ok);
`else
        if (!par_ok) rxd = 1'b1;
`endif
        drive_bit(1'b1);
    endtask

    initial begin
        // Reset values.
        clks(3);
        rst = 1'b0;
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_idle", 32'(idle), 32'd0);
        clks(3 * BitClk);
        check("idle_after_reset", 32'(idle), 32'd1);

        // Single 8N1 frame with consumer ready.
        rx_ready = 1'b1;
        w0 = word_cnt;
        v0 = vld_cycles;
        send_frame(8'hA5, 1'b1);
        clks(BitClk);
        check("a5_count", 32'(word_cnt - w0), 32'd1);
        check("a5_data", 32'(last_data), 32'hA5);
        check("a5_ferr", 32'(last_ferr), 32'd0);
        check("a5_perr", 32'(last_perr), 32'd0);
        check("a5_no_overrun", 32'(ovr_cnt), 32'd0);
        check("a5_valid_pulse", 32'(vld_cycles - v0), 32'd1);
        clks(2 * BitClk);
        check("a5_idle", 32'(idle), 32'd1);

        // Consumer stalled: second word dropped with one overrun pulse.
        rx_ready = 1'b0;
        w0 = word_cnt;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        clks(BitClk);
        check("hold_valid", 32'(rx_valid), 32'd1);
        check("hold_data", 32'(rx_data), 32'h3C);
        check("overrun_once", 32'(ovr_cnt), 32'd1);
        check("hold_no_accept", 32'(word_cnt - w0), 32'd0);
        rx_ready = 1'b1;
        clks(1);
        check("accept_drops_valid", 32'(rx_valid), 32'd0);
        check("accept_data", 32'(last_data), 32'h3C);
        check("accept_count", 32'(word_cnt - w0), 32'd1);

        // Break: 20 bit times low gives exactly one zero word with frame error.
        w0 = word_cnt;
        rxd = 1'b0;
        clks(20 * BitClk);
        rxd = 1'b1;
        clks(3 * BitClk);
        check("break_count", 32'(word_cnt - w0), 32'd1);
        check("break_data", 32'(last_data), 32'h00);
        check("break_ferr", 32'(last_ferr), 32'd1);
        clks(5 * BitClk);
        check("break_single", 32'(word_cnt - w0), 32'd1);
        send_frame(8'h96, 1'b1);
        clks(BitClk);
        check("post_break_count", 32'(word_cnt - w0), 32'd2);
        check("post_break_data", 32'(last_data), 32'h96);
        check("post_break_ferr", 32'(last_ferr), 32'd0);

        // Short low glitch: false start, no word, idle returns.
        clks(2 * BitClk);
        check("pre_glitch_idle", 32'(idle), 32'd1);
        w0 = word_cnt;
        rxd = 1'b0;
        clks(16);
        check("glitch_idle_low", 32'(idle), 32'd0);
        rxd = 1'b1;
        clks(3 * BitClk);
        check("glitch_idle_back", 32'(idle), 32'd1);
        check("glitch_no_word", 32'(word_cnt - w0), 32'd0);
        check("glitch_no_valid", 32'(rx_valid), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so parity bit 1 is correct.
        send_frame(8'h07, 1'b0);
        clks(BitClk);
        check("par_bad_data", 32'(last_data), 32'h07);
        check("par_bad_err", 32'(last_perr), 32'd1);
        send_frame(8'h07, 1'b1);
        clks(BitClk);
        check("par_good_err", 32'(last_perr), 32'd0);
`endif

        // Reset mid-frame discards both the held word and the partial frame.
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        clks(BitClk);
        check("pre_rst_held", 32'(rx_valid), 32'd1);
        w0 = word_cnt;
        // Start plus bits 0..3 of 0xF0; the remaining bits are all high.
        for (int i = 0; i < 5; i++) drive_bit(1'b0);
        rxd = 1'b1;
        rst = 1'b1;
        clks(1);
        rst = 1'b0;
        check("mid_rst_valid", 32'(rx_valid), 32'd0);
        check("mid_rst_data", 32'(rx_data), 32'd0);
        check("mid_rst_ferr", 32'(frame_err), 32'd0);
        check("mid_rst_perr", 32'(parity_err), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        check("mid_rst_idle", 32'(idle), 32'd0);
        clks(6 * BitClk);
        check("mid_rst_no_word", 32'(rx_valid), 32'd0);
        rx_ready = 1'b1;
        send_frame(8'h5A, 1'b1);
        clks(BitClk);
        check("after_rst_count", 32'(word_cnt - w0), 32'd1);
        check("after_rst_data", 32'(last_data), 32'h5A);
        check("after_rst_ferr", 32'(last_ferr), 32'd0);
        check("overrun_total", 32'(ovr_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
